multiplicador_algoritmico: RTL and testbench

- Iterative shift-and-add signed multiplier. It is the inverse arithmetic companion of the divider datapath and shares its Start/Done handshake and its sign-magnitude processing scheme.
- Operands are two's complement. The block converts them to magnitudes plus sign bits, runs one add/shift step per clock, then re-applies the sign.
- One result in flight at a time. It feeds the same downstream consumers that take divider results.

---
 rtl/multiplicador_algoritmico.sv | 104 ++++++++++
 tb/tb_multiplicador_algoritmico.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/multiplicador_algoritmico.sv
// Iterative signed shift-and-add multiplier. Operands become magnitudes plus a sign bit,
// one add/shift step runs per clock, and the sign is re-applied in a final FIX cycle.
module multiplicador_algoritmico #(
  parameter int tamanyo = 32
) (
  input  logic                     CLK,
  input  logic                     RSTa,
  input  logic                     Start,
  input  logic [tamanyo-1:0]       A,
  input  logic [tamanyo-1:0]       B,
  output logic [2*tamanyo-1:0]     P,
  output logic                     Busy,
  output logic                     Done
);

  localparam int CW = $clog2(tamanyo);

  typedef enum logic [1:0] {IDLE, OPERATE, FIX} state_t;

  state_t                 state_q, state_d;
  logic [tamanyo-1:0]     mag_a_q, mag_a_d;
  logic [tamanyo-1:0]     mult_q, mult_d;
  logic [tamanyo-1:0]     accu_q, accu_d;
  logic                   sign_q, sign_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [2*tamanyo-1:0]   p_q, p_d;
  logic                   done_q, done_d;
  logic                   busy_q, busy_d;

  logic [tamanyo:0]       sum;
  logic [2*tamanyo-1:0]   product;

  always_ff @(posedge CLK or negedge RSTa) begin
    if (!RSTa) begin
      state_q <= IDLE;
      mag_a_q <= '0;
      mult_q  <= '0;
      accu_q  <= '0;
      sign_q  <= 1'b0;
      cnt_q   <= '0;
      p_q     <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mag_a_q <= mag_a_d;
      mult_q  <= mult_d;
      accu_q  <= accu_d;
      sign_q  <= sign_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mag_a_d = mag_a_q;
    mult_d  = mult_q;
    accu_d  = accu_q;
    sign_d  = sign_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    done_d  = 1'b0;
    busy_d  = busy_q;
    // Carry of the partial-product addition is kept and shifted into ACCU.
    sum     = {1'b0, accu_q} + (mult_q[0] ? {1'b0, mag_a_q} : '0);
    product = {accu_q, mult_q};

    unique case (state_q)
      IDLE: begin
        if (Start) begin
          // -2^(tamanyo-1) negates to itself, which reads correctly as unsigned 2^(tamanyo-1).
          mag_a_d = A[tamanyo-1] ? (~A + 1'b1) : A;
          mult_d  = B[tamanyo-1] ? (~B + 1'b1) : B;
          sign_d  = A[tamanyo-1] ^ B[tamanyo-1];
          accu_d  = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = OPERATE;
        end
      end
      OPERATE: begin
        accu_d = sum[tamanyo:1];
        mult_d = {sum[0], mult_q[tamanyo-1:1]};
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CW'(tamanyo - 1)) state_d = FIX;
      end
      FIX: begin
        p_d     = sign_q ? -product : product;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign P    = p_q;
  assign Done = done_q;
  assign Busy = busy_q;

endmodule

// File: tb/tb_multiplicador_algoritmico.sv
// Bench for multiplicador_algoritmico: directed vector table with exact latency checks at
// width 8, hand sequences for Start-while-busy, back-to-back and mid-operation reset, and random sweeps.
`timescale 1ns/1ps
module tb_multiplicador_algoritmico;

  logic        CLK = 1'b0;
  logic        RSTa = 1'b0;
  logic        Start8 = 1'b0, Start16 = 1'b0, Start32 = 1'b0;
  logic [7:0]  A8 = '0, B8 = '0;
  logic [15:0] A16 = '0, B16 = '0;
  logic [31:0] A32 = '0, B32 = '0;
  logic [15:0] P8;
  logic [31:0] P16;
  logic [63:0] P32;
  logic        Busy8, Done8, Busy16, Done16, Busy32, Done32;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  multiplicador_algoritmico #(.tamanyo(8)) dut8 (
    .CLK(CLK), .RSTa(RSTa), .Start(Start8), .A(A8), .B(B8),
    .P(P8), .Busy(Busy8), .Done(Done8));
  multiplicador_algoritmico #(.tamanyo(16)) dut16 (
    .CLK(CLK), .RSTa(RSTa), .Start(Start16), .A(A16), .B(B16),
    .P(P16), .Busy(Busy16), .Done(Done16));
  multiplicador_algoritmico #(.tamanyo(32)) dut32 (
    .CLK(CLK), .RSTa(RSTa), .Start(Start32), .A(A32), .B(B32),
    .P(P32), .Busy(Busy32), .Done(Done32));

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Start for one cycle, then require Busy over the 8 OPERATE edges and Done/P exactly 9 edges after acceptance.
  task automatic mul8(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp, input string nm);
    int bad;
    bad = 0;
    @(negedge CLK); Start8 = 1'b1; A8 = a; B8 = b;
    @(negedge CLK); Start8 = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      @(negedge CLK);
      if (Busy8 !== 1'b1 || Done8 !== 1'b0) bad++;
    end
    chk({nm, " busy window"}, 64'(bad), 64'd0);
    @(negedge CLK);
    chk({nm, " done"}, 64'(Done8), 64'd1);
    chk({nm, " P"}, 64'(P8), 64'(exp));
    chk({nm, " busy at done"}, 64'(Busy8), 64'd0);
    @(negedge CLK);
    chk({nm, " done drop"}, 64'(Done8), 64'd0);
  endtask

  task automatic rnd16(input int n);
    logic [15:0] a, b;
    int ref_p;
    bit got;
    for (int i = 0; i < n; i++) begin
      a = 16'($urandom); b = 16'($urandom);
      ref_p = int'($signed(a)) * int'($signed(b));
      @(negedge CLK); Start16 = 1'b1; A16 = a; B16 = b;
      @(negedge CLK); Start16 = 1'b0;
      got = 1'b0;
      for (int j = 0; j < 40 && !got; j++) begin
        @(negedge CLK);
        if (Done16) got = 1'b1;
      end
      if (!got) chk("rand16 timeout", 64'd0, 64'd1);
      else chk("rand16 P", 64'(P16), 64'(unsigned'(ref_p)));
    end
  endtask

  task automatic rnd32(input int n);
    logic [31:0] a, b;
    longint ref_p;
    bit got;
    for (int i = 0; i < n; i++) begin
      a = $urandom; b = $urandom;
      if (i == 0) begin a = 32'h8000_0000; b = 32'h8000_0000; end
      ref_p = longint'($signed(a)) * longint'($signed(b));
      @(negedge CLK); Start32 = 1'b1; A32 = a; B32 = b;
      @(negedge CLK); Start32 = 1'b0;
      got = 1'b0;
      for (int j = 0; j < 60 && !got; j++) begin
        @(negedge CLK);
        if (Done32) got = 1'b1;
      end
      if (!got) chk("rand32 timeout", 64'd0, 64'd1);
      else chk("rand32 P", P32, 64'(ref_p));
    end
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bad;
    logic [7:0] ra, rb;
    int rp;

    vecs[0] = '{8'd7,   8'd3,   16'h0015};
    vecs[1] = '{8'hFB,  8'd12,  16'hFFC4};
    vecs[2] = '{8'h80,  8'h80,  16'h4000};
    vecs[3] = '{8'h80,  8'h7F,  16'hC080};
    vecs[4] = '{8'd0,   8'hFF,  16'h0000};
    vecs[5] = '{8'hFF,  8'hFF,  16'h0001};
    vecs[6] = '{8'h7F,  8'h7F,  16'h3F01};
    vecs[7] = '{8'hFF,  8'h7F,  16'hFF81};
    vecs[8] = '{8'd0,   8'd0,   16'h0000};
    vecs[9] = '{8'hFD,  8'd0,   16'h0000};

    // Reset values
    @(negedge CLK); @(negedge CLK);
    chk("reset P", 64'(P8), 64'd0);
    chk("reset Done", 64'(Done8), 64'd0);
    chk("reset Busy", 64'(Busy8), 64'd0);
    RSTa = 1'b1;
    bad = 0;
    for (int j = 0; j < 20; j++) begin
      @(negedge CLK);
      if (Done8 !== 1'b0 || Busy8 !== 1'b0) bad++;
    end
    chk("idle no done", 64'(bad), 64'd0);

    for (int i = 0; i < 10; i++)
      mul8(vecs[i].a, vecs[i].b, vecs[i].p, $sformatf("vec%0d", i));

    // Start while busy is ignored
    @(negedge CLK); Start8 = 1'b1; A8 = 8'd9; B8 = 8'd9;
    @(negedge CLK); Start8 = 1'b0;
    @(negedge CLK);
    @(negedge CLK); Start8 = 1'b1; A8 = 8'd2; B8 = 8'd2;
    @(negedge CLK); Start8 = 1'b0;
    bad = 0;
    for (int j = 4; j <= 8; j++) begin
      @(negedge CLK);
      if (Done8 !== 1'b0) bad++;
    end
    chk("busy ignore early done", 64'(bad), 64'd0);
    @(negedge CLK);
    chk("busy ignore done", 64'(Done8), 64'd1);
    chk("busy ignore P", 64'(P8), 64'd81);
    bad = 0;
    for (int j = 0; j < 12; j++) begin
      @(negedge CLK);
      if (Done8 !== 1'b0) bad++;
    end
    chk("busy ignore no second done", 64'(bad), 64'd0);
    chk("busy ignore P hold", 64'(P8), 64'd81);

    // Back-to-back: Start during the Done cycle
    @(negedge CLK); Start8 = 1'b1; A8 = 8'd4; B8 = 8'd5;
    @(negedge CLK); Start8 = 1'b0;
    for (int j = 1; j <= 8; j++) @(negedge CLK);
    @(negedge CLK);
    chk("b2b first done", 64'(Done8), 64'd1);
    chk("b2b first P", 64'(P8), 64'd20);
    Start8 = 1'b1; A8 = 8'd2; B8 = 8'd3;
    @(negedge CLK); Start8 = 1'b0;
    bad = 0;
    for (int j = 1; j <= 8; j++) begin
      @(negedge CLK);
      if (Done8 !== 1'b0 || Busy8 !== 1'b1) bad++;
    end
    chk("b2b second busy window", 64'(bad), 64'd0);
    @(negedge CLK);
    chk("b2b second done", 64'(Done8), 64'd1);
    chk("b2b second P", 64'(P8), 64'd6);

    // Reset mid-operation
    @(negedge CLK); Start8 = 1'b1; A8 = 8'd15; B8 = 8'd15;
    @(negedge CLK); Start8 = 1'b0;
    for (int j = 1; j <= 3; j++) @(negedge CLK);
    @(posedge CLK);
    #1 RSTa = 1'b0;
    #1;
    chk("midreset P", 64'(P8), 64'd0);
    chk("midreset Busy", 64'(Busy8), 64'd0);
    chk("midreset Done", 64'(Done8), 64'd0);
    @(negedge CLK); RSTa = 1'b1;
    bad = 0;
    for (int j = 0; j < 20; j++) begin
      @(negedge CLK);
      if (Done8 !== 1'b0 || Busy8 !== 1'b0) bad++;
    end
    chk("midreset no done", 64'(bad), 64'd0);
    mul8(8'd1, 8'd1, 16'd1, "after reset");

    // Random sweeps
    for (int i = 0; i < 300; i++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      rp = int'($signed(ra)) * int'($signed(rb));
      mul8(ra, rb, 16'(rp), "rand8");
    end
    rnd16(300);
    rnd32(300);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
